// File: rtl/nox_mem_arbiter.sv
// nox_mem_arbiter: shares one core-bus memory port between fetch (m0) and LSU (m1).
// LSU has fixed priority, and a starvation counter bounds how long fetch can lose.
// A stalled grant stays locked to its owner until the slave accepts it.
// An in-order ownership FIFO steers each slave response back to the master that issued it.
module nox_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 8
) (
    input  logic                               clk,
    input  logic                               arst,

    // master 0 (instruction fetch)
    input  logic                               m0_req_valid_i,
    output logic                               m0_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]              m0_req_addr_i,
    input  logic                               m0_req_we_i,
    input  logic [DATA_WIDTH-1:0]              m0_req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]            m0_req_wstrb_i,
    output logic                               m0_rsp_valid_o,
    input  logic                               m0_rsp_ready_i,
    output logic [DATA_WIDTH-1:0]              m0_rsp_rdata_o,
    output logic                               m0_rsp_err_o,

    // master 1 (LSU)
    input  logic                               m1_req_valid_i,
    output logic                               m1_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]              m1_req_addr_i,
    input  logic                               m1_req_we_i,
    input  logic [DATA_WIDTH-1:0]              m1_req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]            m1_req_wstrb_i,
    output logic                               m1_rsp_valid_o,
    input  logic                               m1_rsp_ready_i,
    output logic [DATA_WIDTH-1:0]              m1_rsp_rdata_o,
    output logic                               m1_rsp_err_o,

    // shared slave port
    output logic                               s_req_valid_o,
    input  logic                               s_req_ready_i,
    output logic [ADDR_WIDTH-1:0]              s_req_addr_o,
    output logic                               s_req_we_o,
    output logic [DATA_WIDTH-1:0]              s_req_wdata_o,
    output logic [DATA_WIDTH/8-1:0]            s_req_wstrb_o,
    input  logic                               s_rsp_valid_i,
    output logic                               s_rsp_ready_o,
    input  logic [DATA_WIDTH-1:0]              s_rsp_rdata_i,
    input  logic                               s_rsp_err_i,

    // status
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               unexpected_rsp_o
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_W-1:0]     wstrb;
    } req_t;

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // registers
    state_t               r_state;
    logic                 r_owner;
    logic [STARVE_W-1:0]  r_starve_cnt;
    logic                 r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_unexpected;

    // combinational nets
    state_t               w_state_nxt;
    logic                 w_owner_nxt;
    logic [STARVE_W-1:0]  w_starve_nxt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_starved;
    logic                 w_winner;
    logic                 w_win_valid;
    logic                 w_grant;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_head;
    req_t                 w_m0_req;
    req_t                 w_m1_req;
    req_t                 w_s_req;

    assign w_full    = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty   = (r_count == CNT_W'(0));
    assign w_starved = (r_starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign w_head    = r_fifo[r_rd_ptr];

    assign w_m0_req = '{addr: m0_req_addr_i, we: m0_req_we_i,
                        wdata: m0_req_wdata_i, wstrb: m0_req_wstrb_i};
    assign w_m1_req = '{addr: m1_req_addr_i, we: m1_req_we_i,
                        wdata: m1_req_wdata_i, wstrb: m1_req_wstrb_i};

    // Winner select: the locked owner, else LSU unless fetch has starved
    always_comb begin
        w_winner = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_winner = r_owner;
        end else if (m0_req_valid_i && m1_req_valid_i) begin
            w_winner = ~w_starved;
        end else if (m1_req_valid_i) begin
            w_winner = 1'b1;
        end
    end

    // Request mux; a full FIFO blocks both the slave valid and the master readies
    always_comb begin
        w_win_valid    = w_winner ? m1_req_valid_i : m0_req_valid_i;
        w_s_req        = w_winner ? w_m1_req : w_m0_req;
        s_req_valid_o  = w_win_valid & ~w_full;
        w_grant        = s_req_valid_o & s_req_ready_i;
        m0_req_ready_o = w_grant & ~w_winner;
        m1_req_ready_o = w_grant & w_winner;
        w_push         = w_grant;
        s_req_addr_o   = w_s_req.addr;
        s_req_we_o     = w_s_req.we;
        s_req_wdata_o  = w_s_req.wdata;
        s_req_wstrb_o  = w_s_req.wstrb;
    end

    // Lock FSM next state: hold the grant on a stalled request until it is accepted
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_UNLOCKED: begin
                if (s_req_valid_o && !s_req_ready_i) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = w_winner;
                end
            end
            ST_LOCKED: begin
                if (w_push) begin
                    w_state_nxt = ST_UNLOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_UNLOCKED;
            end
        endcase
    end

    // Lock FSM state register
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= ST_UNLOCKED;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Starvation counter: counts fetch cycles spent waiting, saturating at the limit
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!m0_req_valid_i || (w_push && !w_winner)) begin
            w_starve_nxt = STARVE_W'(0);
        end else if (!w_starved) begin
            w_starve_nxt = r_starve_cnt + STARVE_W'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_starve_cnt <= STARVE_W'(0);
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Response steering to the FIFO head owner; nothing is routed while the FIFO is empty
    always_comb begin
        m0_rsp_valid_o = ~w_empty & ~w_head & s_rsp_valid_i;
        m1_rsp_valid_o = ~w_empty &  w_head & s_rsp_valid_i;
        m0_rsp_err_o   = ~w_empty & ~w_head & s_rsp_err_i;
        m1_rsp_err_o   = ~w_empty &  w_head & s_rsp_err_i;
        m0_rsp_rdata_o = s_rsp_rdata_i;
        m1_rsp_rdata_o = s_rsp_rdata_i;
        s_rsp_ready_o  = ~w_empty & (w_head ? m1_rsp_ready_i : m0_rsp_ready_i);
        w_pop          = s_rsp_valid_i & s_rsp_ready_o;
    end

    // Occupancy next value; a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Ownership FIFO storage and pointers; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                r_fifo[i] <= 1'b0;
            end
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_winner;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Sticky flag for a slave response that arrives while no request is outstanding
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_unexpected <= 1'b0;
        end else if (s_rsp_valid_i && w_empty) begin
            r_unexpected <= 1'b1;
        end
    end

    assign outstanding_o    = r_count;
    assign unexpected_rsp_o = r_unexpected;

endmodule

// File: tb/tb_nox_mem_arbiter.sv
// Directed testbench for nox_mem_arbiter with default parameters (depth 4, starve limit 8).
module tb_nox_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          arst;
    logic          m0_req_valid_i, m0_req_ready_o, m0_req_we_i;
    logic [AW-1:0] m0_req_addr_i;
    logic [DW-1:0] m0_req_wdata_i;
    logic [3:0]    m0_req_wstrb_i;
    logic          m0_rsp_valid_o, m0_rsp_ready_i, m0_rsp_err_o;
    logic [DW-1:0] m0_rsp_rdata_o;
    logic          m1_req_valid_i, m1_req_ready_o, m1_req_we_i;
    logic [AW-1:0] m1_req_addr_i;
    logic [DW-1:0] m1_req_wdata_i;
    logic [3:0]    m1_req_wstrb_i;
    logic          m1_rsp_valid_o, m1_rsp_ready_i, m1_rsp_err_o;
    logic [DW-1:0] m1_rsp_rdata_o;
    logic          s_req_valid_o, s_req_ready_i, s_req_we_o;
    logic [AW-1:0] s_req_addr_o;
    logic [DW-1:0] s_req_wdata_o;
    logic [3:0]    s_req_wstrb_o;
    logic          s_rsp_valid_i, s_rsp_ready_o, s_rsp_err_i;
    logic [DW-1:0] s_rsp_rdata_i;
    logic [2:0]    outstanding_o;
    logic          unexpected_rsp_o;

    int checks = 0;
    int errors = 0;

    nox_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .arst(arst),
        .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
        .m0_req_addr_i(m0_req_addr_i), .m0_req_we_i(m0_req_we_i),
        .m0_req_wdata_i(m0_req_wdata_i), .m0_req_wstrb_i(m0_req_wstrb_i),
        .m0_rsp_valid_o(m0_rsp_valid_o), .m0_rsp_ready_i(m0_rsp_ready_i),
        .m0_rsp_rdata_o(m0_rsp_rdata_o), .m0_rsp_err_o(m0_rsp_err_o),
        .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
        .m1_req_addr_i(m1_req_addr_i), .m1_req_we_i(m1_req_we_i),
        .m1_req_wdata_i(m1_req_wdata_i), .m1_req_wstrb_i(m1_req_wstrb_i),
        .m1_rsp_valid_o(m1_rsp_valid_o), .m1_rsp_ready_i(m1_rsp_ready_i),
        .m1_rsp_rdata_o(m1_rsp_rdata_o), .m1_rsp_err_o(m1_rsp_err_o),
        .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
        .s_req_addr_o(s_req_addr_o), .s_req_we_o(s_req_we_o),
        .s_req_wdata_o(s_req_wdata_o), .s_req_wstrb_o(s_req_wstrb_o),
        .s_rsp_valid_i(s_rsp_valid_i), .s_rsp_ready_o(s_rsp_ready_o),
        .s_rsp_rdata_i(s_rsp_rdata_i), .s_rsp_err_i(s_rsp_err_i),
        .outstanding_o(outstanding_o), .unexpected_rsp_o(unexpected_rsp_o)
    );

    always #5 clk = ~clk;

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_valid_i = 1'b0; m0_req_addr_i = '0; m0_req_we_i = 1'b0;
        m0_req_wdata_i = '0;   m0_req_wstrb_i = '0; m0_rsp_ready_i = 1'b0;
        m1_req_valid_i = 1'b0; m1_req_addr_i = '0; m1_req_we_i = 1'b0;
        m1_req_wdata_i = '0;   m1_req_wstrb_i = '0; m1_rsp_ready_i = 1'b0;
        s_req_ready_i  = 1'b0; s_rsp_valid_i = 1'b0; s_rsp_rdata_i = '0;
        s_rsp_err_i    = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] hs;
        arst = 1'b0;
        idle_inputs();
        #1;
        hs = {s_req_valid_o, m0_req_ready_o, m1_req_ready_o,
              m0_rsp_valid_o, m1_rsp_valid_o, s_rsp_ready_o};
        checks++;
        if (hs !== 6'b0) begin
            errors++; $display("FAIL reset_handshakes got %b exp 000000", hs);
        end
        checks++;
        if ({outstanding_o, unexpected_rsp_o} !== 4'b0) begin
            errors++; $display("FAIL reset_status got %0d/%0b exp 0/0", outstanding_o, unexpected_rsp_o);
        end
        step();
        arst = 1'b1;
        step();
        hs = {s_req_valid_o, m0_req_ready_o, m1_req_ready_o,
              m0_rsp_valid_o, m1_rsp_valid_o, s_rsp_ready_o};
        checks++;
        if (hs !== 6'b0 || outstanding_o !== 3'd0) begin
            errors++; $display("FAIL post_reset got %b/%0d exp 000000/0", hs, outstanding_o);
        end
    endtask

    task automatic test_single();
        m0_req_valid_i = 1'b1; m0_req_addr_i = 32'h8000_0000; s_req_ready_i = 1'b1;
        #1;
        checks++;
        if (s_req_addr_o !== 32'h8000_0000 || {s_req_valid_o, m0_req_ready_o, m1_req_ready_o} !== 3'b110) begin
            errors++; $display("FAIL single_req got %h %b exp 80000000 110", s_req_addr_o,
                               {s_req_valid_o, m0_req_ready_o, m1_req_ready_o});
        end
        step();
        m0_req_valid_i = 1'b0; s_req_ready_i = 1'b0;
        #1;
        checks++;
        if (outstanding_o !== 3'd1) begin
            errors++; $display("FAIL single_outstanding got %0d exp 1", outstanding_o);
        end
        s_rsp_valid_i = 1'b1; s_rsp_rdata_i = 32'h1234_5678; m0_rsp_ready_i = 1'b1;
        #1;
        checks++;
        if ({m0_rsp_valid_o, m1_rsp_valid_o, s_rsp_ready_o} !== 3'b101 || m0_rsp_rdata_o !== 32'h1234_5678) begin
            errors++; $display("FAIL single_rsp got %b %h exp 101 12345678",
                               {m0_rsp_valid_o, m1_rsp_valid_o, s_rsp_ready_o}, m0_rsp_rdata_o);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (outstanding_o !== 3'd0) begin
            errors++; $display("FAIL single_drain got %0d exp 0", outstanding_o);
        end
        step();
    endtask

    task automatic test_contention();
        logic q[$];
        logic exp_m0;
        logic head;
        m0_req_valid_i = 1'b1; m0_req_addr_i = 32'h1000_0000;
        m1_req_valid_i = 1'b1; m1_req_addr_i = 32'h2000_0000;
        s_req_ready_i = 1'b1; m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
        for (int k = 0; k < 18; k++) begin
            exp_m0 = ((k % 9) == 8);
            s_rsp_valid_i = (k > 0);
            s_rsp_rdata_i = 32'(k);
            #1;
            checks++;
            if ({m0_req_ready_o, m1_req_ready_o} !== {exp_m0, ~exp_m0}) begin
                errors++; $display("FAIL contention_grant k=%0d got %b exp %b", k,
                                   {m0_req_ready_o, m1_req_ready_o}, {exp_m0, ~exp_m0});
            end
            checks++;
            if (s_req_addr_o !== (exp_m0 ? 32'h1000_0000 : 32'h2000_0000)) begin
                errors++; $display("FAIL contention_addr k=%0d got %h", k, s_req_addr_o);
            end
            if (k > 0) begin
                head = q.pop_front();
                checks++;
                if ({m0_rsp_valid_o, m1_rsp_valid_o} !== {~head, head} || outstanding_o !== 3'd1) begin
                    errors++; $display("FAIL contention_route k=%0d got %b/%0d exp %b/1", k,
                                       {m0_rsp_valid_o, m1_rsp_valid_o}, outstanding_o, {~head, head});
                end
            end
            q.push_back(~exp_m0);
            step();
        end
        m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b0;
        head = q.pop_front();
        #1;
        checks++;
        if ({m0_rsp_valid_o, m1_rsp_valid_o} !== {~head, head}) begin
            errors++; $display("FAIL contention_last got %b exp %b",
                               {m0_rsp_valid_o, m1_rsp_valid_o}, {~head, head});
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (outstanding_o !== 3'd0) begin
            errors++; $display("FAIL contention_drain got %0d exp 0", outstanding_o);
        end
        step();
    endtask

    task automatic test_lock();
        m0_req_valid_i = 1'b1; m0_req_addr_i = 32'h0000_00A0;
        for (int k = 0; k < 5; k++) begin
            if (k >= 3) begin
                m1_req_valid_i = 1'b1; m1_req_addr_i = 32'h0000_00B0;
            end
            #1;
            checks++;
            if (s_req_addr_o !== 32'h0000_00A0 || {s_req_valid_o, m0_req_ready_o, m1_req_ready_o} !== 3'b100) begin
                errors++; $display("FAIL lock_hold k=%0d got %h %b exp 000000a0 100", k, s_req_addr_o,
                                   {s_req_valid_o, m0_req_ready_o, m1_req_ready_o});
            end
            step();
        end
        s_req_ready_i = 1'b1;
        #1;
        checks++;
        if (s_req_addr_o !== 32'h0000_00A0 || {m0_req_ready_o, m1_req_ready_o} !== 2'b10) begin
            errors++; $display("FAIL lock_release got %h %b exp 000000a0 10", s_req_addr_o,
                               {m0_req_ready_o, m1_req_ready_o});
        end
        step();
        m0_req_valid_i = 1'b0;
        #1;
        checks++;
        if (s_req_addr_o !== 32'h0000_00B0 || {m0_req_ready_o, m1_req_ready_o} !== 2'b01) begin
            errors++; $display("FAIL lock_next got %h %b exp 000000b0 01", s_req_addr_o,
                               {m0_req_ready_o, m1_req_ready_o});
        end
        step();
        m1_req_valid_i = 1'b0; s_req_ready_i = 1'b0;
        s_rsp_valid_i = 1'b1; m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
        #1;
        checks++;
        if ({m0_rsp_valid_o, m1_rsp_valid_o} !== 2'b10 || outstanding_o !== 3'd2) begin
            errors++; $display("FAIL lock_rsp0 got %b/%0d exp 10/2", {m0_rsp_valid_o, m1_rsp_valid_o}, outstanding_o);
        end
        step();
        checks++;
        if ({m0_rsp_valid_o, m1_rsp_valid_o} !== 2'b01) begin
            errors++; $display("FAIL lock_rsp1 got %b exp 01", {m0_rsp_valid_o, m1_rsp_valid_o});
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_full();
        logic exp_heads[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        m0_req_valid_i = 1'b1; m0_req_addr_i = 32'h0000_0100; s_req_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (m0_req_ready_o !== 1'b1) begin
                errors++; $display("FAIL full_fill k=%0d got %b exp 1", k, m0_req_ready_o);
            end
            step();
        end
        m1_req_valid_i = 1'b1; m1_req_addr_i = 32'h0000_0200;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (outstanding_o !== 3'd4 || {s_req_valid_o, m0_req_ready_o, m1_req_ready_o} !== 3'b000) begin
                errors++; $display("FAIL full_block k=%0d got %0d %b exp 4 000", k, outstanding_o,
                                   {s_req_valid_o, m0_req_ready_o, m1_req_ready_o});
            end
            step();
        end
        s_rsp_valid_i = 1'b1; m0_rsp_ready_i = 1'b1;
        #1;
        checks++;
        if ({m0_rsp_valid_o, s_rsp_ready_o, s_req_valid_o} !== 3'b110) begin
            errors++; $display("FAIL full_pop got %b exp 110", {m0_rsp_valid_o, s_rsp_ready_o, s_req_valid_o});
        end
        step();
        s_rsp_valid_i = 1'b0;
        #1;
        checks++;
        if (outstanding_o !== 3'd3 || {s_req_valid_o, m0_req_ready_o, m1_req_ready_o} !== 3'b101) begin
            errors++; $display("FAIL full_reopen got %0d %b exp 3 101", outstanding_o,
                               {s_req_valid_o, m0_req_ready_o, m1_req_ready_o});
        end
        step();
        m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b0; s_req_ready_i = 1'b0;
        m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1; s_rsp_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({m0_rsp_valid_o, m1_rsp_valid_o} !== {~exp_heads[k], exp_heads[k]}) begin
                errors++; $display("FAIL full_drain k=%0d got %b", k, {m0_rsp_valid_o, m1_rsp_valid_o});
            end
            step();
        end
        idle_inputs();
        #1;
        checks++;
        if (outstanding_o !== 3'd0) begin
            errors++; $display("FAIL full_empty got %0d exp 0", outstanding_o);
        end
        step();
    endtask

    task automatic test_backpressure_err();
        m1_req_valid_i = 1'b1; m1_req_addr_i = 32'h0000_0300; s_req_ready_i = 1'b1;
        step();
        idle_inputs();
        s_rsp_valid_i = 1'b1; s_rsp_err_i = 1'b1; m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({s_rsp_ready_o, m0_rsp_valid_o, m1_rsp_valid_o, m0_rsp_err_o, m1_rsp_err_o} !== 5'b00101
                || outstanding_o !== 3'd1) begin
                errors++; $display("FAIL bp_stall k=%0d got %b/%0d exp 00101/1", k,
                                   {s_rsp_ready_o, m0_rsp_valid_o, m1_rsp_valid_o, m0_rsp_err_o, m1_rsp_err_o},
                                   outstanding_o);
            end
            step();
        end
        m1_rsp_ready_i = 1'b1;
        #1;
        checks++;
        if ({s_rsp_ready_o, m0_rsp_valid_o, m1_rsp_valid_o, m0_rsp_err_o, m1_rsp_err_o} !== 5'b10101) begin
            errors++; $display("FAIL bp_accept got %b exp 10101",
                               {s_rsp_ready_o, m0_rsp_valid_o, m1_rsp_valid_o, m0_rsp_err_o, m1_rsp_err_o});
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (outstanding_o !== 3'd0 || unexpected_rsp_o !== 1'b0) begin
            errors++; $display("FAIL bp_drain got %0d/%b exp 0/0", outstanding_o, unexpected_rsp_o);
        end
        step();
    endtask

    task automatic test_reset_unexpected();
        m0_req_valid_i = 1'b1; m0_req_addr_i = 32'h0000_0400; s_req_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) step();
        idle_inputs();
        #1;
        checks++;
        if (outstanding_o !== 3'd3) begin
            errors++; $display("FAIL ru_three got %0d exp 3", outstanding_o);
        end
        arst = 1'b0;
        #1;
        checks++;
        if (outstanding_o !== 3'd0) begin
            errors++; $display("FAIL ru_async_clear got %0d exp 0", outstanding_o);
        end
        step();
        arst = 1'b1;
        step();
        s_rsp_valid_i = 1'b1;
        #1;
        checks++;
        if ({s_rsp_ready_o, m0_rsp_valid_o, m1_rsp_valid_o, unexpected_rsp_o} !== 4'b0000) begin
            errors++; $display("FAIL ru_empty_rsp got %b exp 0000",
                               {s_rsp_ready_o, m0_rsp_valid_o, m1_rsp_valid_o, unexpected_rsp_o});
        end
        step();
        s_rsp_valid_i = 1'b0;
        #1;
        checks++;
        if (unexpected_rsp_o !== 1'b1) begin
            errors++; $display("FAIL ru_set got %b exp 1", unexpected_rsp_o);
        end
        step();
        step();
        checks++;
        if (unexpected_rsp_o !== 1'b1) begin
            errors++; $display("FAIL ru_sticky got %b exp 1", unexpected_rsp_o);
        end
        arst = 1'b0;
        #1;
        checks++;
        if (unexpected_rsp_o !== 1'b0) begin
            errors++; $display("FAIL ru_cleared got %b exp 0", unexpected_rsp_o);
        end
        step();
        arst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_full();
        test_backpressure_err();
        test_reset_unexpected();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nox_mem_arbiter.md
Name: nox_mem_arbiter

Overview:
- Two-master to one-slave core-bus arbiter that shares a single memory port between instruction fetch (master 0) and LSU (master 1).
- Sits between the fetch/LSU core-bus interfaces and a single core-bus-to-AXI bridge, for SoC configurations with one unified memory port.
- Provides fixed LSU priority with a fetch anti-starvation counter, grant locking while a request is stalled, and an in-order ownership FIFO that routes responses back to the issuing master.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, read/write data width; wstrb width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, ownership FIFO depth (power of 2, >=2); maximum accepted requests awaiting response.
- STARVE_LIMIT, 8, consecutive cycles master 0 may lose arbitration before it is forced to win.

Ports:
- clk  in  1  core clock.
- arst  in  1  asynchronous reset, active-low.
- m{0,1}_req_valid_i  in  1  master request valid.
- m{0,1}_req_ready_o  out  1  master request accepted.
- m{0,1}_req_addr_i  in  ADDR_WIDTH  request address.
- m{0,1}_req_we_i  in  1  1 = write, 0 = read.
- m{0,1}_req_wdata_i  in  DATA_WIDTH  write data.
- m{0,1}_req_wstrb_i  in  DATA_WIDTH/8  byte strobes.
- m{0,1}_rsp_valid_o  out  1  response valid to master.
- m{0,1}_rsp_ready_i  in  1  master can take response.
- m{0,1}_rsp_rdata_o  out  DATA_WIDTH  read data; driven from the shared slave bus to both masters.
- m{0,1}_rsp_err_o  out  1  bus error for this response.
- s_req_valid_o / s_req_ready_i / s_req_addr_o / s_req_we_o / s_req_wdata_o / s_req_wstrb_o  out/in/out/out/out/out  as above  slave request channel.
- s_rsp_valid_i / s_rsp_ready_o / s_rsp_rdata_i / s_rsp_err_i  in/out/in/in  1/1/DATA_WIDTH/1  slave response channel.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  ownership FIFO occupancy.
- unexpected_rsp_o  out  1  sticky: slave response seen while FIFO empty.

Behaviour:
- Reset (arst low, async): FIFO empty, outstanding_o=0, starve counter=0, lock cleared, unexpected_rsp_o=0. Every valid/ready output is 0 while reset is asserted and in the first cycle after release with no inputs. Reset mid-transaction drops all pending responses.
- States: UNLOCKED and LOCKED(owner). In UNLOCKED, winner selection is combinational in the same cycle:
  - only one master valid -> that master wins;
  - both valid -> m1 wins, unless starve_cnt == STARVE_LIMIT, in which case m0 wins.
- Request mux: s_req_* = winner's fields, s_req_valid_o = winner valid AND FIFO not full. winner_req_ready_o = s_req_ready_i AND FIFO not full. The loser's ready is 0. Zero added latency on the request path.
- Lock: if s_req_valid_o=1 and s_req_ready_i=0, enter LOCKED(winner) next cycle. In LOCKED only the owner is muxed, whatever the other master's valid or the starve count. Return to UNLOCKED on the owner's handshake. Masters must hold valid and fields until accepted.
- FIFO full (outstanding_o == MAX_OUTSTANDING): s_req_valid_o=0, both master readies 0, no lock is taken. The full check uses the registered count, so a same-cycle pop does not unblock a push.
- Handshake (s_req_valid_o & s_req_ready_i): push owner ID (0/1) into the FIFO. Writes are pushed too; the slave returns exactly one response per request, in order.
- Starve counter: increments, saturating at STARVE_LIMIT, on each cycle m0_req_valid_i=1 and m0 is not handshaken. Clears to 0 on an m0 handshake or when m0_req_valid_i=0.
- Response path (combinational, zero latency): with head = FIFO head ID,
  - m[head]_rsp_valid_o = s_rsp_valid_i, the other master's rsp_valid = 0;
  - s_rsp_ready_o = m[head]_rsp_ready_i;
  - rsp_err goes to the head master only.
  - s_rsp_valid_i & s_rsp_ready_o pops the FIFO.
- FIFO empty: s_rsp_ready_o=0, all master rsp_valid=0. If s_rsp_valid_i=1 here, set unexpected_rsp_o, which holds until reset.
- Simultaneous push and pop: occupancy unchanged, pointers both advance, mod MAX_OUTSTANDING wrap.

Test Plan:
- Single master: m0 reads addr 0x8000_0000, slave ready=1 -> s_req_addr_o=0x8000_0000 in the same cycle, outstanding_o=1. Slave responds rdata=0x1234_5678 -> m0_rsp_valid_o=1 with that data, m1_rsp_valid_o=0, outstanding_o=0.
- Contention: both masters valid every cycle, slave always ready, STARVE_LIMIT=8 -> m1 wins 8 consecutive grants, m0 gets the 9th, pattern repeats. The ownership FIFO routes each response to the correct master.
- Lock: m0 wins with s_req_ready_i=0 for 3 cycles, then m1 asserts valid -> s_req_* stays on m0 until its handshake, then m1 is granted next cycle.
- Full: MAX_OUTSTANDING=4, 4 requests accepted, no responses -> s_req_valid_o=0 and both readies 0. One response popped -> next cycle a request is accepted again.
- Backpressure and error: head=m1, m1_rsp_ready_i=0 for 2 cycles, s_rsp_err_i=1 -> s_rsp_ready_o=0 for those cycles, then m1_rsp_err_o=1 on the handshake and m0 never sees a response.
- Reset/unexpected: assert arst with 3 outstanding -> outstanding_o=0 immediately. After release, a slave response with an empty FIFO sets unexpected_rsp_o=1, which stays 1 until the next reset.
